// File: rtl/b10_resp_capture_if.sv
// Read-side handshake of the b10 response-capture trace FIFO.
// master = producer (the capture stage), slave = consumer.
interface b10_resp_capture_if #(
  parameter int DW = 22
);
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/b10_resp_capture.sv
// b10 response capture: samples {cts, ctr, v_out}, logs changes (or obs-flagged
// cycles) as time-stamped entries into a trace FIFO, and folds every enabled
// sample into a 16-bit MISR signature.
module b10_resp_capture #(
  parameter int          DEPTH   = 16,
  parameter int          STAMP_W = 16,
  parameter logic [15:0] POLY    = 16'h1021
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     cts_i,
  input  logic                     ctr_i,
  input  logic [3:0]               v_out_i,
  input  logic                     obs_i,
  b10_resp_capture_if.master       rd,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o,
  output logic [15:0]              signature_o
);
  localparam int           AW   = $clog2(DEPTH);
  localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [5:0]         smp;
  } entry_t;

  // FIRST is not held in a register: the edge that sees enable rise out of
  // IDLE is itself the FIRST capture, so the state register only needs to
  // remember whether the previous edge was enabled.
  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [5:0]         smp, prev_q;
  logic [STAMP_W-1:0] stamp_q;
  logic [15:0]        sig_q, sig_d;
  entry_t             mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_q, drop_d;
  logic               cap, pop, push_ok, drop;

  assign smp = {cts_i, ctr_i, v_out_i};

  // Capture decision and next state.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          cap     = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        if (!enable_i) state_d = IDLE;
        else           cap     = (smp != prev_q) || obs_i;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // MISR next value: shift, polynomial feedback, fold in the sample.
  always_comb begin
    sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {10'b0, smp};
  end

  // Sample history, cycle stamp and MISR advance only on enabled cycles.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_q  <= '0;
      stamp_q <= '0;
      sig_q   <= '0;
    end else if (enable_i) begin
      prev_q  <= smp;
      stamp_q <= stamp_q + 1'b1;
      sig_q   <= sig_d;
    end
  end

  assign pop     = rd.rd_valid && rd.rd_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok = cap && !clear_i && ((count_q != FULL) || pop);
  assign drop    = cap && !clear_i && !push_ok;

  // FIFO pointer/occupancy/overflow bookkeeping; clear discards everything,
  // including a capture arriving on the same edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
      end
    end
  end

  // FIFO control registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clock_i) begin
    if (!reset_i && push_ok) mem[wr_ptr_q] <= '{stamp: stamp_q, smp: smp};
  end

  // Head entry comes straight from storage and the head pointer, both
  // registers, so nothing on the read port depends on this cycle's inputs.
  assign rd.rd_valid = (count_q != '0);
  assign rd.rd_data  = mem[rd_ptr_q];
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = drop_q;
  assign signature_o = sig_q;
endmodule

// File: tb/tb_b10_resp_capture.sv
// Bench for b10_resp_capture: queue-based reference model checked every
// cycle, plus literal expectations at the test-plan milestones.
module tb_b10_resp_capture;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset, enable, clear, cts, ctr, obs;
  logic [3:0]  v_out;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [15:0] signature;

  b10_resp_capture_if #(.DW(22)) rif ();

  b10_resp_capture #(.DEPTH(DEPTH), .STAMP_W(16), .POLY(16'h1021)) dut (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .clear_i(clear),
    .cts_i(cts), .ctr_i(ctr), .v_out_i(v_out), .obs_i(obs),
    .rd(rif),
    .count_o(count), .overflow_o(overflow), .drop_cnt_o(drop_cnt),
    .signature_o(signature)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: trace queue of {stamp, S}, stamp counter, MISR value,
  // last sample, and whether the previous edge was enabled.
  logic [21:0] mq[$];
  logic [15:0] m_stamp, m_sig;
  logic [5:0]  m_prev;
  bit          m_en_prev, m_ovf, started = 0;
  int          m_drop;

  always @(posedge clock) begin
    logic [5:0]  s;
    logic [21:0] entry;
    bit          cap, pop;
    s = {cts, ctr, v_out};
    if (reset) begin
      mq.delete();
      m_stamp = 0; m_sig = 0; m_prev = 0; m_en_prev = 0; m_ovf = 0; m_drop = 0;
      started = 1;
    end else begin
      pop   = (mq.size() != 0) && rif.rd_ready;
      cap   = 0;
      entry = '0;
      if (enable) begin
        cap     = !m_en_prev || (s != m_prev) || obs;
        entry   = {m_stamp, s};
        m_sig   = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ {10'b0, s};
        m_prev  = s;
        m_stamp = m_stamp + 16'd1;
      end
      if (clear) begin
        mq.delete();
        m_ovf = 0; m_drop = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (cap) begin
          if (mq.size() < DEPTH) mq.push_back(entry);
          else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
      m_en_prev = enable;
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clock) begin
    if (started) begin
      chk("rd_valid",  64'(rif.rd_valid), 64'(mq.size() != 0));
      chk("count",     64'(count),        64'(mq.size()));
      chk("overflow",  64'(overflow),     64'(m_ovf));
      chk("drop_cnt",  64'(drop_cnt),     64'(m_drop));
      chk("signature", 64'(signature),    64'(m_sig));
      if (mq.size() != 0) chk("rd_data", 64'(rif.rd_data), 64'(mq[0]));
    end
  end

  task automatic cyc(input bit en, input logic [5:0] s, input bit ob, input bit rdy, input bit clr);
    enable = en; {cts, ctr, v_out} = s; obs = ob; rif.rd_ready = rdy; clear = clr;
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 6'h00, 0, 0, 0);
    cyc(0, 6'h00, 0, 0, 0);
    reset = 1'b0;
  endtask

  logic [15:0] sig_hold;

  initial begin
    reset = 1'b1; enable = 0; clear = 0; cts = 0; ctr = 0; v_out = 0; obs = 0;
    rif.rd_ready = 0;

    // 1: constant sample, single FIRST entry, MISR values
    do_reset();
    chk("t1_reset_valid", 64'(rif.rd_valid), 64'd0);
    chk("t1_reset_sig",   64'(signature),    64'h0);
    cyc(1, 6'h2A, 0, 0, 0);
    chk("t1_sig1",  64'(signature),    64'h002A);
    chk("t1_valid", 64'(rif.rd_valid), 64'd1);
    chk("t1_entry", 64'(rif.rd_data),  64'({16'd0, 6'h2A}));
    cyc(1, 6'h2A, 0, 0, 0);
    chk("t1_sig2",  64'(signature),    64'h007E);
    cyc(1, 6'h2A, 0, 0, 0);
    chk("t1_count", 64'(count),        64'd1);

    // 2: v_out 0,1,1,2 with consumer ready
    do_reset();
    cyc(1, 6'h00, 0, 1, 0);
    cyc(1, 6'h01, 0, 1, 0);
    cyc(1, 6'h01, 0, 1, 0);
    chk("t2_no_stamp2", 64'(count), 64'd0);
    cyc(1, 6'h02, 0, 1, 0);
    chk("t2_entry3", 64'(rif.rd_data), 64'({16'd3, 6'h02}));
    cyc(1, 6'h02, 0, 1, 0);

    // 3: constant sample, obs on cycles 4 and 5
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 6'h15, (i == 4 || i == 5), 0, 0);
    chk("t3_count", 64'(count),       64'd3);
    chk("t3_head",  64'(rif.rd_data), 64'({16'd0, 6'h15}));
    for (int i = 0; i < 4; i++) cyc(1, 6'h15, 0, 1, 0);

    // 4: overflow by 3, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) cyc(1, 6'(i + 1), 0, 0, 0);
    chk("t4_count", 64'(count),       64'd16);
    chk("t4_ovf",   64'(overflow),    64'd1);
    chk("t4_drop",  64'(drop_cnt),    64'd3);
    chk("t4_head",  64'(rif.rd_data), 64'({16'd0, 6'd1}));
    for (int i = 0; i < DEPTH; i++) cyc(1, 6'(DEPTH + 3), 0, 1, 0);
    chk("t4_drained", 64'(count), 64'd0);

    // 5: full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 6'(i + 1), 0, 0, 0);
    cyc(1, 6'd40, 0, 1, 0);
    chk("t5_count", 64'(count),       64'd16);
    chk("t5_drop",  64'(drop_cnt),    64'd0);
    chk("t5_ovf",   64'(overflow),    64'd0);
    chk("t5_head",  64'(rif.rd_data), 64'({16'd1, 6'd2}));
    for (int i = 0; i < DEPTH; i++) cyc(1, 6'd40, 0, 1, 0);

    // 6: enable gap, forced FIRST capture, clear
    sig_hold = m_sig;
    cyc(0, 6'd7, 0, 0, 0);
    cyc(0, 6'd9, 1, 0, 0);
    chk("t6_sig_frozen", 64'(signature), 64'(sig_hold));
    cyc(1, 6'd40, 0, 0, 0);
    chk("t6_first",  64'(rif.rd_data), 64'({16'd33, 6'd40}));
    for (int i = 0; i < 4; i++) cyc(1, 6'(i + 50), 0, 0, 0);
    chk("t6_count5", 64'(count), 64'd5);
    sig_hold = m_sig;
    cyc(0, 6'd3, 0, 0, 1);
    chk("t6_clr_count", 64'(count),        64'd0);
    chk("t6_clr_valid", 64'(rif.rd_valid), 64'd0);
    chk("t6_clr_sig",   64'(signature),    64'(sig_hold));
    cyc(1, 6'd4, 0, 0, 1);
    chk("t6_clr_cap",   64'(count),        64'd0);
    chk("t6_clr_drop",  64'(drop_cnt),     64'd0);

    // mid-stream reset discards entries
    cyc(1, 6'd5, 0, 0, 0);
    cyc(1, 6'd6, 0, 0, 0);
    do_reset();
    chk("t7_reset_count", 64'(count), 64'd0);
    chk("t7_reset_sig",   64'(signature), 64'd0);

    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
